// File: rtl/cache_mem_arbiter_if.sv
// Cache-to-memory arbiter bus: I/D cache request ports and the single memory port.
// slave = arbiter side, master = caches plus memory side.
interface cache_mem_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    localparam int LINE_W = 4 * WORD_SIZE;

    logic                 i_req;
    logic [15:0]          i_addr;
    logic [LINE_W-1:0]    i_rdata;
    logic                 i_done;

    logic                 d_req;
    logic                 d_we;
    logic [15:0]          d_addr;
    logic [LINE_W-1:0]    d_wdata;
    logic [LINE_W-1:0]    d_rdata;
    logic                 d_done;

    logic                 m_readM;
    logic                 m_writeM;
    logic [15:0]          m_address;
    logic [WORD_SIZE-1:0] m_wdata;
    logic [WORD_SIZE-1:0] m_rdata;

    logic                 busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_done, d_rdata, d_done,
        output m_readM, m_writeM, m_address, m_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_done, d_rdata, d_done,
        input  m_readM, m_writeM, m_address, m_wdata, busy
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I/D cache line fills and write-backs onto one memory port.
// Optional MEM_ARB_RR_EN: round-robin on simultaneous requests (else D priority).
module cache_mem_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int LATENCY   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    cache_mem_arbiter_if.slave  bus
);
    localparam int BLOCK_WORDS = 4;
    localparam int LINE_W      = BLOCK_WORDS * WORD_SIZE;
    localparam logic [2:0] LAT_MAX   = 3'(LATENCY - 1);
    localparam logic [1:0] BEAT_LAST = 2'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [13:0]       line_q, line_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic [1:0]        beat_q, beat_d;
    logic [2:0]        lat_q, lat_d;
    logic              grant_d;

    // word-offset address bits are don't-care: lines are always aligned
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // simultaneous requests go to the port not granted last
    always_comb begin
        grant_d = bus.d_req & (~bus.i_req | ~last_q);
    end
`else
    // D-cache wins whenever it is requesting
    always_comb begin
        grant_d = bus.d_req;
    end
`endif

    // transaction sequencing: grant, beat/latency counting, read capture
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        line_d    = line_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
`ifdef MEM_ARB_RR_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_d = ACCESS;
                    owner_d = grant_d;
                    we_d    = grant_d & bus.d_we;
                    line_d  = grant_d ? bus.d_addr[15:2] : bus.i_addr[15:2];
                    wdata_d = bus.d_wdata;
                    beat_d  = 2'd0;
                    lat_d   = 3'd0;
`ifdef MEM_ARB_RR_EN
                    last_d  = grant_d;
`endif
                end
            end
            ACCESS: begin
                if (lat_q == LAT_MAX) begin
                    lat_d = 3'd0;
                    if (!we_q) begin
                        if (owner_q)
                            d_rdata_d[int'(beat_q)*WORD_SIZE +: WORD_SIZE] = bus.m_rdata;
                        else
                            i_rdata_d[int'(beat_q)*WORD_SIZE +: WORD_SIZE] = bus.m_rdata;
                    end
                    if (beat_q == BEAT_LAST)
                        state_d = DONE;
                    else
                        beat_d = beat_q + 2'd1;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            line_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
`ifdef MEM_ARB_RR_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            line_q    <= line_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
`ifdef MEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    // memory strobes and completion pulses decode from registered state
    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.m_readM   = (state_q == ACCESS) & ~we_q;
        bus.m_writeM  = (state_q == ACCESS) & we_q;
        bus.m_address = (state_q == ACCESS) ? {line_q, beat_q} : 16'h0;
        bus.m_wdata   = '0;
        if ((state_q == ACCESS) && we_q)
            bus.m_wdata = wdata_q[int'(beat_q)*WORD_SIZE +: WORD_SIZE];
        bus.i_done    = (state_q == DONE) & ~owner_q;
        bus.d_done    = (state_q == DONE) & owner_q;
        bus.i_rdata   = i_rdata_q;
        bus.d_rdata   = d_rdata_q;
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: vector table plus corner sequences.
// Memory is a small word array answering reads combinationally.
module tb_cache_mem_arbiter;
    localparam int W   = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.WORD_SIZE(W)) bus ();

    cache_mem_arbiter #(.WORD_SIZE(W), .LATENCY(LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [15:0] mem [64];
    assign bus.m_rdata = bus.m_readM ? mem[bus.m_address[5:0]] : 16'h0;

    int errors = 0;
    int checks = 0;

    logic [15:0] aq [$];
    logic [15:0] wq [$];
    int both_hi = 0;

    always @(posedge clk) begin
        #2;
        if (bus.m_readM && bus.m_writeM) both_hi++;
        if (bus.m_readM || bus.m_writeM) aq.push_back(bus.m_address);
        if (bus.m_writeM) wq.push_back(bus.m_wdata);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int n, output bit gi, output bit gd);
        n = 0; gi = 1'b0; gd = 1'b0;
        repeat (40) begin
            @(negedge clk);
            n++;
            if (bus.i_done || bus.d_done) begin
                gi = bus.i_done;
                gd = bus.d_done;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit          ireq;
        bit          dreq;
        bit          dwe;
        logic [15:0] addr;
        logic [63:0] wdata;
        bit          exp_d;
        logic [63:0] exp_i_rd;
        logic [63:0] exp_d_rd;
        int          exp_n;
    } vec_t;

    vec_t vt [5];

    initial begin
        int n, n2, ndone;
        bit gi, gd;
        bit exp_order [3];
        logic [15:0] ea;

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0;  bus.d_wdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        mem[6'h23] = 16'h6000;
        mem[6'h10] = 16'h1010; mem[6'h11] = 16'h2020;
        mem[6'h12] = 16'h3030; mem[6'h13] = 16'h4040;
        mem[6'h30] = 16'hAAAA; mem[6'h31] = 16'hBBBB;
        mem[6'h32] = 16'hCCCC; mem[6'h33] = 16'hDDDD;

        vt[0] = '{1, 0, 0, 16'h0023, 64'h0, 0,
                  64'h6000_0000_0000_0000, 64'h0, 9};
        vt[1] = '{0, 1, 1, 16'h0040, 64'h4444_3333_2222_1111, 1,
                  64'h6000_0000_0000_0000, 64'h0, 9};
        vt[2] = '{0, 1, 0, 16'h0011, 64'h0, 1,
                  64'h6000_0000_0000_0000, 64'h4040_3030_2020_1010, 9};
        vt[3] = '{1, 0, 0, 16'h0032, 64'h0, 0,
                  64'hDDDD_CCCC_BBBB_AAAA, 64'h4040_3030_2020_1010, 9};
        vt[4] = '{0, 1, 1, 16'h0013, 64'h8888_7777_6666_5555, 1,
                  64'hDDDD_CCCC_BBBB_AAAA, 64'h4040_3030_2020_1010, 9};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(bus.busy), 64'h0);
        chk("rst strobes", 64'({bus.m_readM, bus.m_writeM}), 64'h0);
        chk("rst done", 64'({bus.i_done, bus.d_done}), 64'h0);
        chk("rst i_rdata", bus.i_rdata, 64'h0);
        chk("rst d_rdata", bus.d_rdata, 64'h0);
        reset_n = 1'b1;

        // vector table
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            aq.delete(); wq.delete();
            bus.i_req   = vt[i].ireq;
            bus.d_req   = vt[i].dreq;
            bus.d_we    = vt[i].dwe;
            bus.i_addr  = vt[i].addr;
            bus.d_addr  = vt[i].addr;
            bus.d_wdata = vt[i].wdata;
            wait_done(n, gi, gd);
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
            chk($sformatf("v%0d latency", i), 64'(n), 64'(vt[i].exp_n));
            chk($sformatf("v%0d owner", i), 64'({gi, gd}), 64'({~vt[i].exp_d, vt[i].exp_d}));
            chk($sformatf("v%0d i_rdata", i), bus.i_rdata, vt[i].exp_i_rd);
            chk($sformatf("v%0d d_rdata", i), bus.d_rdata, vt[i].exp_d_rd);
            chk($sformatf("v%0d beats", i), 64'(aq.size()), 64'(8));
            for (int k = 0; k < 8 && k < aq.size(); k++) begin
                ea = {vt[i].addr[15:2], 2'(k / 2)};
                chk($sformatf("v%0d addr%0d", i, k), 64'(aq[k]), 64'(ea));
            end
            chk($sformatf("v%0d writes", i), 64'(wq.size()), vt[i].dwe ? 64'(8) : 64'(0));
            for (int k = 0; k < 8 && k < wq.size(); k++)
                chk($sformatf("v%0d wdata%0d", i, k), 64'(wq[k]),
                    64'(vt[i].wdata[(k / 2) * 16 +: 16]));
            @(negedge clk);
            chk($sformatf("v%0d idle", i),
                64'({bus.busy, bus.i_done, bus.d_done}), 64'h0);
        end

        // simultaneous requests: D first, I queued behind it
        do_reset();
        @(negedge clk);
        bus.i_addr = 16'h0020; bus.d_addr = 16'h0010; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        wait_done(n, gi, gd);
        bus.d_req = 1'b0;
        chk("both first D", 64'({gi, gd}), 64'b01);
        chk("both d lat", 64'(n), 64'(9));
        wait_done(n2, gi, gd);
        bus.i_req = 1'b0;
        chk("both then I", 64'({gi, gd}), 64'b10);
        chk("both i lat", 64'(n + n2), 64'(19));
        chk("both i_rdata", bus.i_rdata, 64'h6000_0000_0000_0000);
        chk("both d_rdata", bus.d_rdata, 64'h4040_3030_2020_1010);

        // both held across three transactions
`ifdef MEM_ARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        @(negedge clk);
        bus.i_addr = 16'h0030; bus.d_addr = 16'h0010; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(n, gi, gd);
            chk($sformatf("held grant%0d", k), 64'({gi, gd}),
                64'({~exp_order[k], exp_order[k]}));
            chk($sformatf("held lat%0d", k), 64'(n), k == 0 ? 64'(9) : 64'(10));
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;

        // request dropped mid-transaction still completes
        do_reset();
        @(negedge clk);
        bus.i_addr = 16'h0020; bus.i_req = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_req = 1'b0;
        wait_done(n, gi, gd);
        chk("drop lat", 64'(n + 2), 64'(9));
        chk("drop done", 64'({gi, gd}), 64'b10);

        // reset during beat 2 of an I fill
        do_reset();
        @(negedge clk);
        aq.delete();
        bus.i_addr = 16'h0030; bus.i_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid addr", 64'(bus.m_address), 64'h32);
        chk("mid i_rdata", bus.i_rdata, 64'h0000_0000_BBBB_AAAA);
        reset_n = 1'b0;
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("abort busy", 64'(bus.busy), 64'h0);
        chk("abort strobes", 64'({bus.m_readM, bus.m_writeM}), 64'h0);
        chk("abort i_rdata", bus.i_rdata, 64'h0);
        reset_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.i_done || bus.d_done) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'h0);

        chk("strobe overlap", 64'(both_hi), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, memory word width in bits.
REQ-002 Parameter LATENCY, default 2, memory cycles per word beat (range 1..7).
REQ-003 Parameter BLOCK_WORDS, fixed at 4, words per cache line.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 i_req  input  1  I-cache line-fill request, level, held until i_done.
REQ-007 i_addr  input  16  I-cache line address; bits [1:0] ignored.
REQ-008 i_rdata  output  64  filled I-line, word b at bits [16b+15:16b].
REQ-009 i_done  output  1  one-cycle pulse: I transaction complete.
REQ-010 d_req  input  1  D-cache request, level, held until d_done.
REQ-011 d_we  input  1  1 = line write-back, 0 = line fill; sampled at grant.
REQ-012 d_addr  input  16  D-cache line address; bits [1:0] ignored.
REQ-013 d_wdata  input  64  write-back line, same word packing as i_rdata.
REQ-014 d_rdata  output  64  filled D-line.
REQ-015 d_done  output  1  one-cycle pulse: D transaction complete.
REQ-016 m_readM / m_writeM  output  1 each  memory read / write strobes.
REQ-017 m_address  output  16  memory word address.
REQ-018 m_wdata  output  16  memory write word; 0 when m_writeM=0.
REQ-019 m_rdata  input  16  memory read word.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states IDLE, ACCESS, DONE; one transaction at a time on the single memory port.
REQ-022 IDLE: if any req high at edge, latch owner, line address {addr[15:2]}, d_we, d_wdata; go to ACCESS; else stay.
REQ-023 Default arbitration: d_req wins when both high in same IDLE cycle.
REQ-024 ACCESS: 4 beats b=0..3, each exactly LATENCY cycles; m_address = {line[15:2], b[1:0]} held for whole beat.
REQ-025 Read beat: m_readM=1 all beat cycles; m_rdata sampled on final beat cycle into owner's rdata word b.
REQ-026 Write beat: m_writeM=1 all beat cycles, m_wdata = latched word b.
REQ-027 m_readM and m_writeM never both high; both low in IDLE and DONE.
REQ-028 After beat 3, go to DONE; DONE pulses owner's done for one cycle, then IDLE.
REQ-029 Latency: req high in IDLE cycle t -> done high in cycle t+1+4*LATENCY (t+9 at LATENCY=2).
REQ-030 Req deassert mid-transaction ignored; transaction completes and done still pulses.
REQ-031 Req still high in IDLE after DONE starts a new transaction (requester must drop req after done).
REQ-032 i_rdata/d_rdata retain value until overwritten by next fill of the same port; write-back leaves d_rdata unchanged.
REQ-033 Non-owner request waits without loss; served on the next IDLE cycle.

Reset
REQ-034 reset_n=0 at edge: state IDLE, beat and latency counters 0, all strobes/done/busy 0, i_rdata/d_rdata 0, last-grant = I.
REQ-035 Reset mid-transaction aborts it at once; no done pulse issued for it.

Configuration
REQ-036 Macro MEM_ARB_RR_EN defined: on simultaneous requests grant the port not granted last (round-robin via last-grant flag; flag updated at every grant).
REQ-037 Macro MEM_ARB_RR_EN undefined: fixed D-priority per REQ-023; last-grant flag absent.

Verification
REQ-038 LATENCY=2, i_req, i_addr=0x23, memory 0x20..0x23 = 0x0,0x0,0x0,0x6000 -> m_address 0x20,0x20,0x21,...,0x23; i_done 9 cycles after req; i_rdata=0x6000_0000_0000_0000.
REQ-039 d_req, d_we=1, d_addr=0x40, d_wdata=0x4444_3333_2222_1111 -> m_writeM 8 cycles, words 0x1111..0x4444 at 0x40..0x43; d_done; d_rdata unchanged.
REQ-040 i_req and d_req same cycle -> D served first; I granted in IDLE after d_done; i_done 19 cycles after original request.
REQ-041 MEM_ARB_RR_EN defined, both held high across three transactions -> grant order D, I, D.
REQ-042 Reset asserted during beat 2 of I fill -> next cycle IDLE, strobes low, i_rdata=0, no i_done.
